// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: states, opcodes and mux/ALU codes.
package riscv_pkg;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps ALUOp plus funct fields to an ALUControl code.
module aludec
  import riscv_pkg::*;
(
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] alu_op,
  output logic [2:0] alu_control
);

  // Fixed add/sub for address and branch work, funct decode for ALU instructions
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (opb5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/controller_multi_cycle.sv
// Moore FSM sequencing the shared-memory multi-cycle RV32I datapath.
module controller_multi_cycle
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       IllegalOp
);

  state_t     state;
  state_t     state_next;
  logic [1:0] alu_op;
  logic       op_ok;
  logic       taken;

  assign op_ok = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                 (op == OP_I)  || (op == OP_B)  || (op == OP_JAL);

  // Branch condition: beq on Zero, bne on !Zero, anything else never taken
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      default: taken = 1'b0;
    endcase
  end

  // State register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_B:         state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = S_FETCH;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      default:    state_next = S_FETCH;
    endcase
  end

  // Per-state output decode; reset masks every write enable and the illegal flag
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    alu_op    = ALUOP_ADD;
    RegWrite  = 1'b0;
    IllegalOp = 1'b0;
    case (state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_IMM;
        IllegalOp = ~op_ok;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_SUB;
        PCWrite = taken;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      IllegalOp = 1'b0;
    end
  end

  // Immediate format selected purely by opcode
  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_SW:            ImmSrc = IMM_S;
      OP_B:             ImmSrc = IMM_B;
      OP_JAL:           ImmSrc = IMM_J;
      OP_LUI, OP_AUIPC: ImmSrc = IMM_U;
      default:          ImmSrc = IMM_I;
    endcase
  end

  aludec u_aludec (
    .opb5        (op[5]),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_op      (alu_op),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_controller_multi_cycle.sv
// Scoreboard bench: stimulus pushes per-cycle expected outputs, a negedge monitor pops and compares.
module tb_controller_multi_cycle;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;

  controller_multi_cycle dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .IllegalOp(IllegalOp)
  );

  always #5 clk = ~clk;

  localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5, ER = 6, EI = 7, AWB = 8, BQ = 9, J = 10;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,RegWrite,IllegalOp}
  logic [17:0] exp_q[$];
  string       name_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  // Hand-written per-state expectation table; xc/tk/im/il are hand-computed per vector
  function automatic logic [17:0] exp_vec(input int st, input logic rst, input logic [2:0] xc,
                                          input logic tk, input logic [2:0] im, input logic il);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] res, sa, sb;
    logic [2:0] ac;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    res = 2'b00; sa = 2'b00; sb = 2'b00; ac = 3'b000;
    case (st)
      F:   begin pcw = 1; irw = 1; res = 2'b10; sb = 2'b10; end
      D:   begin sa = 2'b01; sb = 2'b01; ill = il; end
      MA:  begin sa = 2'b10; sb = 2'b01; end
      MR:  adr = 1;
      MWB: begin res = 2'b01; rw = 1; end
      MW:  begin adr = 1; mw = 1; end
      ER:  begin sa = 2'b10; ac = xc; end
      EI:  begin sa = 2'b10; sb = 2'b01; ac = xc; end
      AWB: rw = 1;
      BQ:  begin sa = 2'b10; ac = 3'b001; pcw = tk; end
      J:   begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      default: ;
    endcase
    if (rst) begin pcw = 0; irw = 0; mw = 0; rw = 0; ill = 0; end
    return {pcw, adr, mw, irw, res, sa, sb, ac, im, rw, ill};
  endfunction

  // One clock cycle of stimulus plus its expected response
  task automatic step(input string nm, input int st, input logic rst, input logic [6:0] o,
                      input logic [2:0] f3, input logic f7, input logic z,
                      input logic [2:0] xc, input logic tk, input logic [2:0] im, input logic il);
    @(posedge clk);
    #1;
    reset = rst; op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    exp_q.push_back(exp_vec(st, rst, xc, tk, im, il));
    name_q.push_back(nm);
  endtask

  // Monitor: compare whatever the DUT presents mid-cycle against the oldest expectation
  always @(negedge clk) begin
    logic [17:0] act, e;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALUControl, ImmSrc, RegWrite, IllegalOp};
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL %s: got %b expected %b", nm, act, e);
      end
    end
  end

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, LU = 7'b0110111;

  initial begin
    reset = 1; op = '0; funct3 = '0; funct7b5 = 0; Zero = 0;
    repeat (2) @(posedge clk);
    step("rst_fetch", F, 1, LW, 3'b000, 0, 0, 3'b000, 0, 3'b000, 0);

    // lw: 5 cycles
    step("lw_f",   F,   0, LW, 3'b010, 0, 0, 3'b000, 0, 3'b000, 0);
    step("lw_d",   D,   0, LW, 3'b010, 0, 0, 3'b000, 0, 3'b000, 0);
    step("lw_ma",  MA,  0, LW, 3'b010, 0, 0, 3'b000, 0, 3'b000, 0);
    step("lw_mr",  MR,  0, LW, 3'b010, 0, 0, 3'b000, 0, 3'b000, 0);
    step("lw_mwb", MWB, 0, LW, 3'b010, 0, 0, 3'b000, 0, 3'b000, 0);
    // sw: 4 cycles
    step("sw_f",   F,   0, SW, 3'b010, 0, 0, 3'b000, 0, 3'b001, 0);
    step("sw_d",   D,   0, SW, 3'b010, 0, 0, 3'b000, 0, 3'b001, 0);
    step("sw_ma",  MA,  0, SW, 3'b010, 0, 0, 3'b000, 0, 3'b001, 0);
    step("sw_mw",  MW,  0, SW, 3'b010, 0, 0, 3'b000, 0, 3'b001, 0);
    // R-type sub / add / slt / or / and
    step("sub_f",  F,   0, RT, 3'b000, 1, 0, 3'b000, 0, 3'b000, 0);
    step("sub_d",  D,   0, RT, 3'b000, 1, 0, 3'b000, 0, 3'b000, 0);
    step("sub_er", ER,  0, RT, 3'b000, 1, 0, 3'b001, 0, 3'b000, 0);
    step("sub_wb", AWB, 0, RT, 3'b000, 1, 0, 3'b000, 0, 3'b000, 0);
    step("add_f",  F,   0, RT, 3'b000, 0, 0, 3'b000, 0, 3'b000, 0);
    step("add_d",  D,   0, RT, 3'b000, 0, 0, 3'b000, 0, 3'b000, 0);
    step("add_er", ER,  0, RT, 3'b000, 0, 0, 3'b000, 0, 3'b000, 0);
    step("add_wb", AWB, 0, RT, 3'b000, 0, 0, 3'b000, 0, 3'b000, 0);
    step("slt_f",  F,   0, RT, 3'b010, 0, 0, 3'b000, 0, 3'b000, 0);
    step("slt_d",  D,   0, RT, 3'b010, 0, 0, 3'b000, 0, 3'b000, 0);
    step("slt_er", ER,  0, RT, 3'b010, 0, 0, 3'b101, 0, 3'b000, 0);
    step("slt_wb", AWB, 0, RT, 3'b010, 0, 0, 3'b000, 0, 3'b000, 0);
    step("or_f",   F,   0, RT, 3'b110, 0, 0, 3'b000, 0, 3'b000, 0);
    step("or_d",   D,   0, RT, 3'b110, 0, 0, 3'b000, 0, 3'b000, 0);
    step("or_er",  ER,  0, RT, 3'b110, 0, 0, 3'b011, 0, 3'b000, 0);
    step("or_wb",  AWB, 0, RT, 3'b110, 0, 0, 3'b000, 0, 3'b000, 0);
    step("and_f",  F,   0, RT, 3'b111, 0, 0, 3'b000, 0, 3'b000, 0);
    step("and_d",  D,   0, RT, 3'b111, 0, 0, 3'b000, 0, 3'b000, 0);
    step("and_er", ER,  0, RT, 3'b111, 0, 0, 3'b010, 0, 3'b000, 0);
    step("and_wb", AWB, 0, RT, 3'b111, 0, 0, 3'b000, 0, 3'b000, 0);
    // addi with funct7b5=1 stays add (op[5]=0)
    step("addi_f", F,   0, IT, 3'b000, 1, 0, 3'b000, 0, 3'b000, 0);
    step("addi_d", D,   0, IT, 3'b000, 1, 0, 3'b000, 0, 3'b000, 0);
    step("addi_ei",EI,  0, IT, 3'b000, 1, 0, 3'b000, 0, 3'b000, 0);
    step("addi_wb",AWB, 0, IT, 3'b000, 1, 0, 3'b000, 0, 3'b000, 0);
    // branches: 3 cycles each
    step("beqt_f", F,   0, BR, 3'b000, 0, 1, 3'b000, 0, 3'b010, 0);
    step("beqt_d", D,   0, BR, 3'b000, 0, 1, 3'b000, 0, 3'b010, 0);
    step("beqt_b", BQ,  0, BR, 3'b000, 0, 1, 3'b000, 1, 3'b010, 0);
    step("beqn_f", F,   0, BR, 3'b000, 0, 0, 3'b000, 0, 3'b010, 0);
    step("beqn_d", D,   0, BR, 3'b000, 0, 0, 3'b000, 0, 3'b010, 0);
    step("beqn_b", BQ,  0, BR, 3'b000, 0, 0, 3'b000, 0, 3'b010, 0);
    step("bnet_f", F,   0, BR, 3'b001, 0, 0, 3'b000, 0, 3'b010, 0);
    step("bnet_d", D,   0, BR, 3'b001, 0, 0, 3'b000, 0, 3'b010, 0);
    step("bnet_b", BQ,  0, BR, 3'b001, 0, 0, 3'b000, 1, 3'b010, 0);
    step("bnen_f", F,   0, BR, 3'b001, 0, 1, 3'b000, 0, 3'b010, 0);
    step("bnen_d", D,   0, BR, 3'b001, 0, 1, 3'b000, 0, 3'b010, 0);
    step("bnen_b", BQ,  0, BR, 3'b001, 0, 1, 3'b000, 0, 3'b010, 0);
    step("blt_f",  F,   0, BR, 3'b100, 0, 1, 3'b000, 0, 3'b010, 0);
    step("blt_d",  D,   0, BR, 3'b100, 0, 1, 3'b000, 0, 3'b010, 0);
    step("blt_b",  BQ,  0, BR, 3'b100, 0, 1, 3'b000, 0, 3'b010, 0);
    // jal: 4 cycles
    step("jal_f",  F,   0, JL, 3'b000, 0, 0, 3'b000, 0, 3'b011, 0);
    step("jal_d",  D,   0, JL, 3'b000, 0, 0, 3'b000, 0, 3'b011, 0);
    step("jal_j",  J,   0, JL, 3'b000, 0, 0, 3'b000, 0, 3'b011, 0);
    step("jal_wb", AWB, 0, JL, 3'b000, 0, 0, 3'b000, 0, 3'b011, 0);
    // unsupported lui: 2 cycles, one-cycle IllegalOp
    step("ill_f",  F,   0, LU, 3'b000, 0, 0, 3'b000, 0, 3'b100, 0);
    step("ill_d",  D,   0, LU, 3'b000, 0, 0, 3'b000, 0, 3'b100, 1);
    // sw interrupted by reset held 3 cycles starting in MEMWRITE
    step("rsw_f",  F,   0, SW, 3'b010, 0, 0, 3'b000, 0, 3'b001, 0);
    step("rsw_d",  D,   0, SW, 3'b010, 0, 0, 3'b000, 0, 3'b001, 0);
    step("rsw_ma", MA,  0, SW, 3'b010, 0, 0, 3'b000, 0, 3'b001, 0);
    step("rsw_mw", MW,  1, SW, 3'b010, 0, 0, 3'b000, 0, 3'b001, 0);
    step("rsw_r1", F,   1, SW, 3'b010, 0, 0, 3'b000, 0, 3'b001, 0);
    step("rsw_r2", F,   1, SW, 3'b010, 0, 0, 3'b000, 0, 3'b001, 0);
    step("post_f", F,   0, LW, 3'b000, 0, 0, 3'b000, 0, 3'b000, 0);
    step("post_d", D,   0, LW, 3'b000, 0, 0, 3'b000, 0, 3'b000, 0);

    @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/controller_multi_cycle.md
Name: controller_multi_cycle

Overview:
Moore-style FSM that sequences the shared-memory, single-ALU multi-cycle RV32I datapath, one instruction at a time.
- Drives PC, IR, memory and register-file write enables, plus operand and result mux selects, from the latched opcode.
- Sits beside the multi-cycle datapath and replaces the combinational single-cycle control path.
- Supports lw, sw, R-type ALU, I-type ALU, beq/bne and jal; any other opcode is flagged and skipped.

Parameters:
STATE_W, 4, width of the state register (11 states used).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
op  in  7  opcode from the IR (instr[6:0])
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
Zero  in  1  ALU zero flag, same cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
MemWrite  out  1  data memory write enable
IRWrite  out  1  IR and OldPC enable
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1 (A)
ALUSrcB  out  2  00=rs2 (WriteData), 01=ImmExt, 10=constant 4
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
RegWrite  out  1  register-file write enable
IllegalOp  out  1  one-cycle pulse in DECODE on an unsupported opcode

Behaviour:
- Clock, reset and state register:
  - One clock, clk. Reset is synchronous and active-high on port reset. The state register updates on the clk rising edge.
  - reset high at an edge: next state = FETCH, regardless of current state. This includes reset mid-instruction; no partial write completes afterwards.
  - While reset is high, PCWrite, IRWrite, MemWrite, RegWrite and IllegalOp are forced to 0. All other outputs follow the current state.
  - After reset deasserts, the first cycle is FETCH.
- Output decode:
  - Outputs are combinational from the state only. Exceptions: PCWrite in BEQ also depends on Zero and funct3; ImmSrc depends on op only.
  - Any output not listed for a state is 0.
  - ALUOp is internal: 00 gives add, 01 gives sub, 10 gives funct decode.
- Per-state outputs and transitions:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCWrite=1. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (precomputes the branch target). Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other opcode -> FETCH, with IllegalOp=1
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next: FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. PCWrite = taken, where:
    - funct3=000: taken = Zero
    - funct3=001: taken = !Zero
    - any other funct3: taken = 0
    - Next: FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Next: ALUWB.
- ALU decode:
  - ALUOp=10 decodes funct3:
    - 000 -> add, except sub when op[5] & funct7b5 = 1
    - 010 -> slt
    - 110 -> or
    - 111 -> and
    - any other funct3 -> add
- Latency in cycles, FETCH to the next FETCH: lw 5, sw 4, R 4, I 4, branch 3, jal 4, illegal 2.
- Unreachable state encodings: next state = FETCH, all enables 0.

Decomposition:
- Shared package riscv_pkg holds:
  - state encodings
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL)
  - ALUControl codes, ImmSrc codes, ALUOp codes
  - mux-select codes for ResultSrc, ALUSrcA and ALUSrcB
- Sub-module: reuse the existing aludec (inputs op[5], funct3, funct7b5, ALUOp; output ALUControl).
- The FSM, output decode and ImmSrc decode stay in this module.

Test Plan:
- Reset held 3 cycles mid-MEMWRITE, then released -> no MemWrite during reset; first cycle after release is FETCH with IRWrite=1, PCWrite=1.
- lw (op=0000011) -> state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in MEMWB with ResultSrc=01; 5 cycles total.
- sw (op=0100011) -> FETCH, DECODE, MEMADR, MEMWRITE; MemWrite=1 and AdrSrc=1 only in MEMWRITE; ImmSrc=001; 4 cycles total.
- R-type sub (funct3=000, funct7b5=1) -> ALUControl=001 in EXECUTER; add (funct7b5=0) -> 000; I-type addi with funct7b5=1 -> 000; slt -> 101.
- beq with Zero=1 -> PCWrite=1 in BEQ; beq with Zero=0 -> PCWrite=0; bne (funct3=001) with Zero=0 -> PCWrite=1; 3 cycles total.
- jal -> JAL state has PCWrite=1, ALUSrcB=10, then ALUWB with RegWrite=1; op=0110111 -> IllegalOp=1 for one DECODE cycle, then FETCH.
